// File: rtl/fifo_reg.sv
// -----------------------------------------------------------------------------
// fifo_reg -- single-clock register-based synchronous FIFO
//
// Stores up to DEPTH words of WIDTH bits. Reads are registered: an accepted
// read loads rdata at the accepting edge and pulses rvalid for the following
// cycle. Status flags are decoded combinationally from the occupancy count.
// Overflow/underflow are sticky error flags, cleared only by flush or reset.
//
// Parameters
//   WIDTH     data width in bits (1..64)
//   DEPTH     number of entries, power of two (4..1024)
//   AE_LEVEL  almost_empty asserted while count <= AE_LEVEL
//   AF_LEVEL  almost_full  asserted while count >= AF_LEVEL
//
// Ports
//   clk           single clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   flush         synchronous clear of pointers, count, rvalid, sticky flags
//   wen / wdata   write request and write data
//   ren           read request
//   rdata         registered read data (holds when no read is accepted)
//   rvalid        rdata was updated by the previous edge
//   count         current occupancy, 0..DEPTH
//   empty, full, almost_empty, almost_full   occupancy status flags
//   overflow      sticky: write attempted while full with no accepted read
//   underflow     sticky: read attempted while empty
// -----------------------------------------------------------------------------
module fifo_reg #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AE_LEVEL = 2,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wen,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     ren,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     underflow
);

  // ---------------------------------------------------------------------------
  // Derived widths and threshold constants
  // ---------------------------------------------------------------------------
  localparam int AW = $clog2(DEPTH);   // pointer width
  localparam int CW = AW + 1;          // count width, must reach DEPTH itself

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [AW-1:0] P_ONE   = AW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;
  logic             r_overflow;
  logic             r_underflow;

  // ---------------------------------------------------------------------------
  // Combinational status and handshake decode
  // ---------------------------------------------------------------------------
  logic w_empty;
  logic w_full;
  logic w_rd_accept;
  logic w_wr_accept;
  logic w_ovf_event;
  logic w_udf_event;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);

  // A read is accepted only from a non-empty FIFO, so a same-cycle write into
  // an empty FIFO never falls through to rdata. A flush cycle ignores both
  // requests entirely.
  assign w_rd_accept = ren & ~w_empty & ~flush;

  // While full, a write is still accepted when a read frees a slot at the
  // same edge; the read pointer moves off the slot the write pointer targets.
  assign w_wr_accept = wen & (~w_full | w_rd_accept) & ~flush;

  assign w_ovf_event = wen & ~w_wr_accept & ~flush;
  assign w_udf_event = ren &  w_empty     & ~flush;

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the data array has no reset and is not cleared by flush; validity
  // is defined only by the pointers and count, and leaving it unreset lets
  // the array map onto plain flops or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy count
  // ---------------------------------------------------------------------------
  // NOTE: every sequential block uses non-blocking assignments so all state
  // updates at an edge see the pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow wraps
      // DEPTH-1 -> 0 without any compare logic.
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + P_ONE;
      end
      if (w_rd_accept) begin
        r_rd_ptr <= r_rd_ptr + P_ONE;
      end
      unique case ({w_wr_accept, w_rd_accept})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------------
  // rdata deliberately holds through flush and through rejected reads; only
  // reset zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_accept;
      if (w_rd_accept) begin
        r_rdata <= r_mem[r_rd_ptr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_event) begin
        r_overflow <= 1'b1;
      end
      if (w_udf_event) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rdata        = r_rdata;
  assign rvalid       = r_rvalid;
  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_count <= C_AE);
  assign almost_full  = (r_count >= C_AF);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_reg.sv
// -----------------------------------------------------------------------------
// tb_fifo_reg -- self-checking bench for fifo_reg (default parameters)
//
// A queue-based reference model tracks the FIFO contents, sticky flags and
// the registered read port. Every cycle all DUT outputs are compared with the
// model; directed scenarios add explicit constant checks on key values.
// -----------------------------------------------------------------------------
module tb_fifo_reg;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 16;
  localparam int AE_LEVEL = 2;
  localparam int AF_LEVEL = DEPTH - 2;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             wen;
  logic [WIDTH-1:0] wdata;
  logic             ren;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  fifo_reg #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AE_LEVEL (AE_LEVEL),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wen          (wen),
    .wdata        (wdata),
    .ren          (ren),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: contents as a queue, plus read port and sticky flags
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_rdata;
  logic             m_rvalid;
  logic             m_ovf;
  logic             m_udf;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  // One clock of FIFO behaviour expressed as queue operations.
  task automatic model_step(input logic w, input logic r, input logic f,
                            input logic [WIDTH-1:0] d);
    bit rd_ok;
    bit wr_ok;
    if (f) begin
      mq.delete();
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
    end else begin
      rd_ok = r && (mq.size() != 0);
      wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
      if (r && mq.size() == 0) m_udf = 1'b1;
      if (w && !wr_ok)         m_ovf = 1'b1;
      if (rd_ok) m_rdata = mq.pop_front();
      m_rvalid = rd_ok;
      if (wr_ok) mq.push_back(d);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    check({tag, ".rdata"},  64'(rdata),        64'(m_rdata));
    check({tag, ".rvalid"}, 64'(rvalid),       64'(m_rvalid));
    check({tag, ".count"},  64'(count),        64'(n));
    check({tag, ".empty"},  64'(empty),        64'(n == 0));
    check({tag, ".full"},   64'(full),         64'(n == DEPTH));
    check({tag, ".ae"},     64'(almost_empty), 64'(n <= AE_LEVEL));
    check({tag, ".af"},     64'(almost_full),  64'(n >= AF_LEVEL));
    check({tag, ".ovf"},    64'(overflow),     64'(m_ovf));
    check({tag, ".udf"},    64'(underflow),    64'(m_udf));
  endtask

  // Drive at the falling edge, let the rising edge act, compare 1 ns later.
  task automatic step(input string tag, input logic w, input logic r,
                      input logic f, input logic [WIDTH-1:0] d);
    @(negedge clk);
    wen   = w;
    ren   = r;
    flush = f;
    wdata = d;
    @(posedge clk);
    model_step(w, r, f, d);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    wen   = 1'b0;
    ren   = 1'b0;
    flush = 1'b0;
    wdata = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed and randomized stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [WIDTH-1:0] d;
    bit w, r, f;
    int wbias, rbias;

    // Reset state, observed with no clock edge involved.
    rst_n = 1'b0;
    flush = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
    wdata = '0;
    model_reset();
    #1;
    check_all("reset");
    check("reset.empty_const", 64'(empty), 64'(1));
    check("reset.af_const",    64'(almost_full), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Three writes then three reads, data out in order one cycle after.
    step("w11", 1, 0, 0, 32'h11);
    step("w22", 1, 0, 0, 32'h22);
    step("w33", 1, 0, 0, 32'h33);
    step("r1", 0, 1, 0, '0);
    check("r1.data", 64'(rdata), 64'h11);
    step("r2", 0, 1, 0, '0);
    check("r2.data", 64'(rdata), 64'h22);
    step("r3", 0, 1, 0, '0);
    check("r3.data", 64'(rdata), 64'h33);
    check("r3.rvalid", 64'(rvalid), 64'(1));
    step("r_idle", 0, 0, 0, '0);
    check("r_idle.empty", 64'(empty), 64'(1));
    check("r_idle.count", 64'(count), 64'(0));

    // Fill to full, then an extra write overflows and is dropped.
    for (int i = 0; i < DEPTH; i++) begin
      step("fill", 1, 0, 0, 32'h100 + 32'(i));
      if (i + 1 == AF_LEVEL) check("fill.af_at_14", 64'(almost_full), 64'(1));
    end
    check("fill.full", 64'(full), 64'(1));
    step("w17", 1, 0, 0, 32'hDEAD);
    check("w17.ovf",   64'(overflow), 64'(1));
    check("w17.count", 64'(count),    64'(DEPTH));

    // Full with simultaneous read and write, across several pointer wraps.
    for (int i = 0; i < 40; i++) begin
      step("full_rw", 1, 1, 0, 32'h200 + 32'(i));
    end
    check("full_rw.count", 64'(count), 64'(DEPTH));

    // Drain: order matches write order.
    for (int i = 0; i < DEPTH; i++) begin
      step("drain", 0, 1, 0, '0);
    end
    check("drain.last", 64'(rdata), 64'h200 + 64'd39);

    // Flush, then empty with simultaneous write and read: no fall-through.
    step("flush0", 0, 0, 1, '0);
    check("flush0.ovf", 64'(overflow), 64'(0));
    step("empty_rw", 1, 1, 0, 32'hAA);
    check("empty_rw.udf",    64'(underflow), 64'(1));
    check("empty_rw.count",  64'(count),     64'(1));
    check("empty_rw.rvalid", 64'(rvalid),    64'(0));
    step("rd_aa", 0, 1, 0, '0);
    check("rd_aa.data", 64'(rdata), 64'hAA);

    // Five entries with overflow set, flush with wen=1 discards everything.
    for (int i = 0; i < DEPTH + 1; i++) step("ld", 1, 0, 0, 32'h300 + 32'(i));
    for (int i = 0; i < DEPTH - 5; i++) step("ld_rd", 0, 1, 0, '0);
    check("ld.count5", 64'(count), 64'(5));
    check("ld.ovf",    64'(overflow), 64'(1));
    step("flush_w", 1, 0, 1, 32'hBEEF);
    check("flush_w.count", 64'(count),    64'(0));
    check("flush_w.empty", 64'(empty),    64'(1));
    check("flush_w.ovf",   64'(overflow), 64'(0));
    step("post_flush_rd", 0, 1, 0, '0);

    // Asynchronous reset between edges with seven entries stored.
    for (int i = 0; i < 8; i++) step("pre_rst", 1, 0, 0, 32'h400 + 32'(i));
    step("pre_rst_rd", 0, 1, 0, '0);
    check("pre_rst.count7", 64'(count), 64'(7));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_rst.rdata0", 64'(rdata), 64'(0));
    idle_inputs();
    rst_n = 1'b1;
    step("rst_w0", 1, 0, 0, 32'h5A5A);
    step("rst_r0", 0, 1, 0, '0);
    check("rst_r0.data", 64'(rdata), 64'h5A5A);

    // Randomized traffic with shifting read/write bias and rare flushes.
    for (int blk = 0; blk < 16; blk++) begin
      wbias = $urandom_range(20, 90);
      rbias = $urandom_range(20, 90);
      for (int i = 0; i < 100; i++) begin
        w = ($urandom_range(0, 99) < wbias);
        r = ($urandom_range(0, 99) < rbias);
        f = ($urandom_range(0, 63) == 0);
        d = $urandom;
        step("rand", w, r, f, d);
      end
    end

    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
